// File: rtl/frequency_meter.sv
// frequency_meter: measures the period of sig_in in clk100MHz cycles and flags a stalled input.
// Optional macro FREQ_METER_AVG_EN publishes the mean of the last four raw periods instead.
module frequency_meter #(
  parameter int PERIOD_W   = 20,
  parameter int MAX_PERIOD = 1_000_000
) (
  input  logic                clk100MHz,
  input  logic                rst,
  input  logic                sig_in,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic                timeout
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic [PERIOD_W-1:0] MAX_CNT = PERIOD_W'(MAX_PERIOD);
  localparam logic [PERIOD_W-1:0] ONE     = PERIOD_W'(1);

  state_t              state;
  state_t              state_next;
  logic                s1;
  logic                s2;
  logic                s3;
  logic                rise;
  logic                at_max;
  logic                raw_valid;
  logic                stall;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] cnt_next;

  // s1/s2 resolve metastability; s3 is only the delayed copy used for edge detection.
  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise   = s2 & ~s3;
  assign at_max = (cnt == MAX_CNT);

  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rise) state_next = MEASURE;
      MEASURE: if (!rise && at_max) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A rise is checked before the limit so a spacing of exactly MAX_PERIOD still reports.
  always_comb begin
    raw_valid = 1'b0;
    stall     = 1'b0;
    cnt_next  = cnt;
    case (state)
      IDLE: begin
        if (rise) cnt_next = ONE;
      end
      MEASURE: begin
        if (rise) begin
          raw_valid = 1'b1;
          cnt_next  = ONE;
        end else if (at_max) begin
          stall    = 1'b1;
          cnt_next = '0;
        end else begin
          cnt_next = cnt + ONE;
        end
      end
      default: cnt_next = '0;
    endcase
  end

  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

`ifdef FREQ_METER_AVG_EN
  logic [PERIOD_W-1:0] hist0;
  logic [PERIOD_W-1:0] hist1;
  logic [PERIOD_W-1:0] hist2;
  logic [PERIOD_W-1:0] hist3;
  logic [2:0]          fill;
  logic                raw_valid_d;
  logic [PERIOD_W+1:0] sum;
  logic                avg_ready;

  // The history is flushed on a stall so stale periods never mix with the resumed signal.
  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      hist0       <= '0;
      hist1       <= '0;
      hist2       <= '0;
      hist3       <= '0;
      fill        <= '0;
      raw_valid_d <= 1'b0;
    end else begin
      raw_valid_d <= raw_valid;
      if (stall) begin
        hist0 <= '0;
        hist1 <= '0;
        hist2 <= '0;
        hist3 <= '0;
        fill  <= '0;
      end else if (raw_valid) begin
        hist0 <= cnt;
        hist1 <= hist0;
        hist2 <= hist1;
        hist3 <= hist2;
        fill  <= (fill == 3'd4) ? 3'd4 : fill + 3'd1;
      end
    end
  end

  assign sum = {2'b00, hist0} + {2'b00, hist1} + {2'b00, hist2} + {2'b00, hist3};
  assign avg_ready = raw_valid_d && (fill == 3'd4);

  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      period       <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= avg_ready;
      if (avg_ready) begin
        period  <= PERIOD_W'(sum >> 2);
        timeout <= 1'b0;
      end else if (stall) begin
        timeout <= 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk100MHz) begin
    if (rst) begin
      period       <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= raw_valid;
      if (raw_valid) begin
        period  <= cnt;
        timeout <= 1'b0;
      end else if (stall) begin
        timeout <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_frequency_meter.sv
// tb_frequency_meter: directed self-checking bench for frequency_meter with a shortened MAX_PERIOD.
// Build with FREQ_METER_AVG_EN defined to exercise the averaging variant instead of the raw tests.
module tb_frequency_meter;

  localparam int PERIOD_W = 20;
  localparam int MAX      = 5000;

  logic                clk100MHz = 1'b0;
  logic                rst       = 1'b1;
  logic                sig_in    = 1'b0;
  logic [PERIOD_W-1:0] period;
  logic                period_valid;
  logic                timeout;

  int                  cycle            = 0;
  int                  checks           = 0;
  int                  errors           = 0;
  int                  valid_cnt        = 0;
  int                  last_valid_cycle = -1;
  int                  width_errs       = 0;
  int                  to_rises         = 0;
  int                  to_rise_cycle    = -1;
  int                  to_fall_cycle    = -1;
  logic [PERIOD_W-1:0] last_period      = '0;
  logic                prev_valid       = 1'b0;
  logic                prev_to          = 1'b0;

  frequency_meter #(
    .PERIOD_W  (PERIOD_W),
    .MAX_PERIOD(MAX)
  ) dut (
    .clk100MHz   (clk100MHz),
    .rst         (rst),
    .sig_in      (sig_in),
    .period      (period),
    .period_valid(period_valid),
    .timeout     (timeout)
  );

  always #5 clk100MHz = ~clk100MHz;

  always @(posedge clk100MHz) cycle <= cycle + 1;

  // Record every valid pulse and timeout transition, sampled half a clock after the edge.
  always @(negedge clk100MHz) begin
    if (period_valid) begin
      valid_cnt        = valid_cnt + 1;
      last_valid_cycle = cycle;
      last_period      = period;
      if (prev_valid) width_errs = width_errs + 1;
    end
    if (timeout && !prev_to) begin
      to_rises      = to_rises + 1;
      to_rise_cycle = cycle;
    end
    if (!timeout && prev_to) to_fall_cycle = cycle;
    prev_valid = period_valid;
    prev_to    = timeout;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic stepCycles(input int n);
    repeat (n) @(posedge clk100MHz);
    #1;
  endtask

  // One input cycle: rising edge now, next rising edge exactly `spacing` clocks later.
  task automatic applyStimulus(input int spacing, output int rise_cycle);
    sig_in     = 1'b1;
    rise_cycle = cycle;
    stepCycles(spacing / 2);
    sig_in = 1'b0;
    stepCycles(spacing - spacing / 2);
  endtask

  initial begin
    $display("[TB] frequency_meter bench start, MAX_PERIOD=%0d", MAX);
    rst    = 1'b1;
    sig_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk100MHz);
      #1;
      sig_in = ~sig_in;
      @(negedge clk100MHz);
      checkOutput("reset period", 32'(period), 0);
      checkOutput("reset valid", 32'(period_valid), 0);
      checkOutput("reset timeout", 32'(timeout), 0);
    end
    @(posedge clk100MHz);
    #1;
    rst    = 1'b0;
    sig_in = 1'b0;
    @(negedge clk100MHz);
    checkOutput("release period", 32'(period), 0);
    checkOutput("release valid", 32'(period_valid), 0);
    checkOutput("release timeout", 32'(timeout), 0);
    stepCycles(1);

`ifdef FREQ_METER_AVG_EN
    begin
      int p [6] = '{100, 200, 300, 400, 500, 100};
      int r;
      int v0;
      v0 = valid_cnt;
      for (int i = 0; i < 6; i++) begin
        applyStimulus(p[i], r);
        if (i == 3) checkOutput("avg no early valid", valid_cnt, v0);
        if (i == 4) begin
          checkOutput("avg first count", valid_cnt, v0 + 1);
          checkOutput("avg first period", 32'(last_period), 250);
          checkOutput("avg first latency", last_valid_cycle, r + 4);
        end
        if (i == 5) begin
          checkOutput("avg second count", valid_cnt, v0 + 2);
          checkOutput("avg second period", 32'(last_period), 350);
          checkOutput("avg second latency", last_valid_cycle, r + 4);
        end
      end
      checkOutput("avg valid width", width_errs, 0);
    end
`else
    begin
      int r, a, b, c, d, e, f, h1, h2, v0, vc, to0;

      v0 = valid_cnt;
      for (int i = 0; i < 4; i++) begin
        applyStimulus(1000, r);
        checkOutput("square valid count", valid_cnt, v0 + i);
        if (i > 0) begin
          checkOutput("square period", 32'(last_period), 1000);
          checkOutput("square latency", last_valid_cycle, r + 3);
        end
      end
      checkOutput("square valid width", width_errs, 0);

      // Input now stays low: wait for the stall flag with a bounded budget.
      to0 = to_rises;
      for (int i = 0; i < MAX + 50 && to_rises == to0; i++) stepCycles(1);
      checkOutput("stall timeout latency", to_rise_cycle, r + 3 + MAX);
      checkOutput("stall timeout level", 32'(timeout), 1);
      checkOutput("stall period hold", 32'(period), 1000);

      applyStimulus(2000, a);
      checkOutput("rearm keeps timeout", 32'(timeout), 1);
      applyStimulus(2000, b);
      checkOutput("resume period", 32'(last_period), 2000);
      checkOutput("resume latency", last_valid_cycle, b + 3);
      checkOutput("resume timeout clear", to_fall_cycle, b + 3);

      applyStimulus(MAX, c);
      to0 = to_rises;
      applyStimulus(MAX, d);
      checkOutput("boundary period", 32'(last_period), MAX);
      checkOutput("boundary latency", last_valid_cycle, d + 3);
      checkOutput("boundary no timeout", to_rises, to0);
      checkOutput("boundary timeout level", 32'(timeout), 0);

      applyStimulus(MAX + 1, e);
      vc = valid_cnt;
      applyStimulus(1000, f);
      checkOutput("over boundary no valid", valid_cnt, vc);
      checkOutput("over boundary timeout", 32'(timeout), 1);
      checkOutput("over boundary latency", to_rise_cycle, e + 3 + MAX);

      // Edge at f+1000 starts a period; reset lands 400 clocks into it.
      sig_in = 1'b1;
      stepCycles(100);
      sig_in = 1'b0;
      stepCycles(300);
      rst = 1'b1;
      stepCycles(2);
      rst = 1'b0;
      checkOutput("midreset period cleared", 32'(period), 0);
      checkOutput("midreset timeout cleared", 32'(timeout), 0);
      vc = valid_cnt;
      stepCycles(600);
      applyStimulus(700, h1);
      checkOutput("midreset first edge", valid_cnt, vc);
      applyStimulus(700, h2);
      checkOutput("midreset count", valid_cnt, vc + 1);
      checkOutput("midreset period", 32'(last_period), 700);
      checkOutput("midreset latency", last_valid_cycle, h2 + 3);
      checkOutput("final valid width", width_errs, 0);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frequency_meter.md
# frequency_meter

Measures the period of an external digital signal, such as a wheel encoder or a reflectance-sensor pulse train, in cycles of the 100 MHz system clock. It is the receiving counterpart of the frequency divider. Where the divider turns a clock count into an output frequency, this block turns an incoming frequency back into a clock count. It sits between the board input pins and the control logic, and publishes one registered period word per input cycle plus a stall/timeout flag.

## Interface
- `PERIOD_W`, default 20: width of the period counter and the `period` output. It must satisfy 2^PERIOD_W > MAX_PERIOD.
- `MAX_PERIOD`, default 1_000_000: longest measurable period in clocks (10 ms, i.e. 100 Hz minimum input frequency).

Ports:
- `clk100MHz`  in  1  system clock, 100 MHz.
- `rst`  in  1  reset, synchronous and active-high.
- `sig_in`  in  1  measured signal, asynchronous to `clk100MHz`.
- `period`  out  PERIOD_W  last measured period, in clock cycles.
- `period_valid`  out  1  one-cycle pulse when `period` is updated.
- `timeout`  out  1  level; set when no rising edge is seen for MAX_PERIOD clocks.

## Operation
- **Synchronizer:** `sig_in` → s1 → s2 → s3. All three flops reset to 0.
- **Edge detect:** `rise = s2 & ~s3`. Only rising edges are measured.
- **Counter `cnt`** (PERIOD_W bits) resets to 0.
- **State IDLE** (reset state): no measurement is in progress.
  - On `rise`: `cnt` ← 1, go to MEASURE.
  - No period is reported for this first edge.
- **State MEASURE:**
  - On `rise`: `period` ← `cnt`, `period_valid` ← 1, `timeout` ← 0, `cnt` ← 1. Stay in MEASURE.
  - Else if `cnt == MAX_PERIOD`: `timeout` ← 1, `cnt` ← 0, go to IDLE. `period` holds its last value.
  - Else: `cnt` ← `cnt` + 1.
- **Result:** consecutive detected rising edges N clocks apart yield `period` = N exactly.
- **Simultaneous events:** if `rise` and `cnt == MAX_PERIOD` occur in the same cycle, `rise` wins. `period` = MAX_PERIOD is reported valid and `timeout` is not set.
- **Clearing `timeout`:** only the next `period_valid` clears it. The first edge after a stall re-arms the block but does not clear `timeout`.
- **Minimum period:** the minimum resolvable period is 2 clocks. Shorter pulses may be missed; this is not an error.
- **Reset values:** `period` = 0, `period_valid` = 0, `timeout` = 0, state = IDLE.
- **Reset mid-measurement:** `rst` discards the partial count and synchronizer contents. After release, the next rising edge starts a fresh measurement; a valid period needs two edges after release.

## Timing
- **Synchronizer latency:** a `sig_in` rising edge sampled at clock k appears as `rise` during cycle k+2.
- **Output update:** `period` and `period_valid` update at the end of the `rise` cycle, so they are visible at k+3.
- **`period_valid` width:** exactly one clock. It deasserts the following cycle unless another `rise` occurs.
- **Timeout latency:** `timeout` rises exactly MAX_PERIOD clocks after the last detected `rise`, registered.
- All outputs are registered; there are no combinational paths from `sig_in`.

## Configuration
- Macro: `FREQ_METER_AVG_EN`.
- **Defined:** the block keeps a 4-entry history of raw periods.
  - `period` = (sum of the last 4 raw periods) >> 2, truncated. The sum uses PERIOD_W+2 bits.
  - `period_valid` fires only once 4 raw periods have been collected since reset or since the last timeout.
  - Output latency grows by one extra clock (k+4).
  - The history and fill count clear on `rst` and on timeout.
- **Undefined:** `period` is the raw single-cycle measurement. No history registers are instantiated.

## Test plan
- **Reset values:** hold `rst` 5 clocks with `sig_in` toggling → `period` = 0, `period_valid` = 0, `timeout` = 0 throughout and one clock after release.
- **Square wave:** 1000-clock square wave (500 high / 500 low) → no valid on the first edge. Then `period` = 1000 with a 1-clock `period_valid` every 1000 clocks, first valid 3 clocks after the second `sig_in` rise.
- **Stall:** stop `sig_in` low after periods of 1000 → `timeout` = 1 exactly MAX_PERIOD clocks after the last `rise`, and `period` stays 1000. Resume at period 2000 → `timeout` clears with the first `period_valid` carrying 2000.
- **Boundary:** edge spacing of exactly MAX_PERIOD → `period` = 1_000_000 valid, `timeout` stays 0. Spacing of MAX_PERIOD+1 → `timeout` = 1 and no valid.
- **Reset mid-measurement:** assert `rst` 400 clocks into a 1000-clock period → the next `period_valid` appears only after two post-reset edges and reports the true spacing.
- **Averaging (macro defined):** periods 100, 200, 300, 400 → a single `period_valid` after the fourth, with `period` = 250. A fifth period of 500 → `period` = 350.
